// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped instruction cache with SETS one-word frames.
//
// A lookup that hits in IDLE is answered combinationally in the same cycle.
// A miss latches the word address, moves to FETCH, and holds a single read
// request to the memory controller until iwait drops. The returned word is
// then written into the frame. An invalidate that arrives during a fetch
// marks that fill as discarded, so the frame is left invalid.
//
// Ports
//   CLK       in   rising-edge clock
//   nRST      in   synchronous reset, active-high
//   imemREN   in   datapath instruction read request
//   imemaddr  in   datapath byte address [31:0]
//   ihit      out  imemload holds the requested word this cycle
//   imemload  out  instruction word to the datapath [31:0]
//   iREN      out  read request to the memory controller
//   iaddr     out  word-aligned fetch address [31:0]
//   iwait     in   memory controller busy (0 = iload valid)
//   iload     in   word from the memory controller [31:0]
//   inval     in   invalidate all frames
// ---------------------------------------------------------------------------
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        inval
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            r_state;
    logic [SETS-1:0]   r_valid;
    logic [TW-1:0]     r_tag  [SETS];
    logic [31:0]       r_data [SETS];
    logic [31:0]       r_addr;
    logic              r_discard;

    logic [IW-1:0]     w_idx;
    logic [TW-1:0]     w_tag;
    logic [IW-1:0]     w_fill_idx;
    logic [TW-1:0]     w_fill_tag;
    logic              w_lookup;
    logic              w_fill;
    logic              w_unused;

    assign w_idx      = imemaddr[IW+1:2];
    assign w_tag      = imemaddr[31:IW+2];
    assign w_fill_idx = r_addr[IW+1:2];
    assign w_fill_tag = r_addr[31:IW+2];
    // Byte offset never affects which word is returned.
    assign w_unused   = &{1'b0, imemaddr[1:0]};

    assign w_lookup = (r_state == IDLE) && imemREN && !inval
                      && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // A fill lands only when the transfer completes, nothing invalidated it
    // during the fetch (now or earlier), and reset is not overriding it.
    assign w_fill = (r_state == FETCH) && !iwait && !r_discard && !inval && !nRST;

    assign ihit     = w_lookup;
    assign imemload = w_lookup ? r_data[w_idx] : 32'd0;
    assign iREN     = (r_state == FETCH);
    assign iaddr    = (r_state == FETCH) ? r_addr : 32'd0;

    // Control state: FSM, valid bits, latched address, discard flag.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state   <= IDLE;
            r_valid   <= '0;
            r_addr    <= 32'd0;
            r_discard <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (inval) begin
                        r_valid <= '0;
                    end else if (imemREN && !w_lookup) begin
                        r_addr    <= {imemaddr[31:2], 2'b00};
                        r_discard <= 1'b0;
                        r_state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (inval) begin
                        r_valid   <= '0;
                        r_discard <= 1'b1;
                    end
                    if (!iwait) begin
                        if (w_fill)
                            r_valid[w_fill_idx] <= 1'b1;
                        r_discard <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Frame storage needs no reset: the valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache -- directed self-checking bench for icache (SETS = 16).
// Inputs change 1 time unit after each rising edge; outputs are checked
// 3 units after the edge, well clear of the next one.
// ---------------------------------------------------------------------------
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        inval;

    int n_cmp = 0;
    int n_bad = 0;

    icache #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .inval    (inval)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Full miss: detect cycle, `waits` busy FETCH cycles, one completing
    // FETCH cycle, then the hit cycle. Returns one step after the hit cycle.
    task automatic do_miss(input string tag, input logic [31:0] a,
                           input logic [31:0] d, input int waits);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1; inval = 1'b0;
        settle();
        chk({tag, ".det_ihit"}, {31'd0, ihit}, 32'd0);
        chk({tag, ".det_iREN"}, {31'd0, iREN}, 32'd0);
        step();
        for (int i = 0; i < waits; i++) begin
            settle();
            chk({tag, ".wait_iREN"}, {31'd0, iREN}, 32'd1);
            chk({tag, ".wait_iaddr"}, iaddr, wa);
            step();
        end
        iwait = 1'b0; iload = d;
        settle();
        chk({tag, ".done_iREN"}, {31'd0, iREN}, 32'd1);
        chk({tag, ".done_iaddr"}, iaddr, wa);
        step();
        iwait = 1'b1; iload = 32'd0;
        settle();
        chk({tag, ".hit_ihit"}, {31'd0, ihit}, 32'd1);
        chk({tag, ".hit_load"}, imemload, d);
        chk({tag, ".hit_iREN"}, {31'd0, iREN}, 32'd0);
        step();
    endtask

    task automatic do_hit(input string tag, input logic [31:0] a, input logic [31:0] d);
        imemREN = 1'b1; imemaddr = a;
        settle();
        chk({tag, ".ihit"}, {31'd0, ihit}, 32'd1);
        chk({tag, ".load"}, imemload, d);
        chk({tag, ".iREN"}, {31'd0, iREN}, 32'd0);
        chk({tag, ".iaddr"}, iaddr, 32'd0);
        step();
    endtask

    initial begin
        nRST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0;
        iwait = 1'b1; iload = 32'd0; inval = 1'b0;
        step();
        step();
        // Reset state (still in reset, after two edges).
        imemREN = 1'b1; imemaddr = 32'h40;
        settle();
        chk("rst.ihit", {31'd0, ihit}, 32'd0);
        chk("rst.load", imemload, 32'd0);
        chk("rst.iREN", {31'd0, iREN}, 32'd0);
        chk("rst.iaddr", iaddr, 32'd0);
        nRST = 1'b0; imemREN = 1'b0;
        step();

        // Cold read with two busy cycles, then a repeat hit.
        do_miss("cold", 32'h40, 32'hDEADBEEF, 2);
        do_hit("rehit", 32'h40, 32'hDEADBEEF);
        // Byte offset resolves to the same word.
        do_hit("off43", 32'h43, 32'hDEADBEEF);

        // Conflict on index 0: 0x80 replaces 0x40, then 0x40 misses again.
        do_miss("conf80", 32'h80, 32'h11112222, 0);
        do_hit("hit80", 32'h80, 32'h11112222);
        do_miss("conf40", 32'h40, 32'hDEADBEEF, 1);

        // Invalidate while both 0x40 and 0x44 are cached.
        do_miss("fill44", 32'h44, 32'h44444444, 0);
        do_hit("hit44", 32'h44, 32'h44444444);
        imemREN = 1'b1; imemaddr = 32'h40; inval = 1'b1;
        settle();
        chk("inv.ihit", {31'd0, ihit}, 32'd0);
        chk("inv.load", imemload, 32'd0);
        step();
        inval = 1'b0; imemREN = 1'b0;
        settle();
        chk("inv.nofetch", {31'd0, iREN}, 32'd0);
        step();
        do_miss("inv40", 32'h40, 32'hDEADBEEF, 0);
        do_miss("inv44", 32'h44, 32'h44444444, 0);

        // inval during FETCH; the datapath also walks away mid-fill.
        imemREN = 1'b1; imemaddr = 32'h48;
        settle();
        chk("fi.det_iREN", {31'd0, iREN}, 32'd0);
        step();
        imemREN = 1'b0; imemaddr = 32'h100; inval = 1'b1;
        settle();
        chk("fi.iREN", {31'd0, iREN}, 32'd1);
        chk("fi.iaddr", iaddr, 32'h48);
        chk("fi.ihit", {31'd0, ihit}, 32'd0);
        step();
        inval = 1'b0; iwait = 1'b0; iload = 32'h48484848;
        settle();
        chk("fi.done_iaddr", iaddr, 32'h48);
        step();
        iwait = 1'b1; iload = 32'd0;
        // Back in IDLE and 0x48 was not kept; 0x40 was wiped as well.
        do_miss("fi48", 32'h48, 32'h5A5A5A5A, 0);
        do_miss("fi40", 32'h40, 32'hDEADBEEF, 0);

        // Reset mid-FETCH while busy.
        imemREN = 1'b1; imemaddr = 32'h4C;
        step();
        settle();
        chk("rf.iREN", {31'd0, iREN}, 32'd1);
        nRST = 1'b1;
        step();
        settle();
        chk("rf.after_iREN", {31'd0, iREN}, 32'd0);
        chk("rf.after_iaddr", iaddr, 32'd0);
        nRST = 1'b0;
        do_miss("rf4C", 32'h4C, 32'h4C4C4C4C, 0);

        // Reset wins over a completing fill on the same edge.
        imemREN = 1'b1; imemaddr = 32'h50;
        step();
        nRST = 1'b1; iwait = 1'b0; iload = 32'h50505050;
        settle();
        chk("rp.iREN", {31'd0, iREN}, 32'd1);
        step();
        nRST = 1'b0; iwait = 1'b1; iload = 32'd0;
        do_miss("rp50", 32'h50, 32'h05050505, 0);
        // Reset also dropped 0x4C.
        do_miss("rp4C", 32'h4C, 32'h4C4C4C4C, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter SETS, default 16, meaning the number of direct-mapped one-word frames (power of two, minimum 2).
REQ-002 The block SHALL have port CLK  in  1  single rising-edge clock.
REQ-003 The block SHALL have port nRST  in  1  synchronous reset, active-high (asserted = 1), sampled on the CLK rising edge.
REQ-004 The block SHALL have port imemREN  in  1  datapath instruction read request.
REQ-005 The block SHALL have port imemaddr  in  32  datapath instruction byte address.
REQ-006 The block SHALL have port ihit  out  1  the requested word is valid on imemload this cycle.
REQ-007 The block SHALL have port imemload  out  32  instruction word returned to the datapath.
REQ-008 The block SHALL have port iREN  out  1  read request to the memory controller.
REQ-009 The block SHALL have port iaddr  out  32  word-aligned address to the memory controller.
REQ-010 The block SHALL have port iwait  in  1  memory controller busy; 0 = iload valid this cycle.
REQ-011 The block SHALL have port iload  in  32  word from the memory controller.
REQ-012 The block SHALL have port inval  in  1  invalidate all frames.

Function
REQ-013 The block SHALL split the address as offset [1:0] (ignored), index [IW+1:2] with IW=log2(SETS), and tag [31:IW+2].
REQ-014 The block SHALL hold per frame a valid bit, a tag and a 32-bit data word.
REQ-015 The block SHALL implement two states, IDLE and FETCH.
REQ-016 In IDLE, the block SHALL assert ihit combinationally in the same cycle when imemREN=1, inval=0, the frame is valid and the tags match, and SHALL drive imemload with the frame data.
REQ-017 The block SHALL drive ihit=0 and imemload=0 whenever imemREN=0, inval=1, state=FETCH, or a lookup misses.
REQ-018 In IDLE, imemREN=1 with a miss and inval=0 SHALL latch {imemaddr[31:2],2'b00} and move the state to FETCH on the next edge.
REQ-019 In FETCH, the block SHALL drive iREN=1 and iaddr=latched address; in IDLE it SHALL drive iREN=0 and iaddr=0.
REQ-020 In FETCH with iwait=0, the block SHALL on that edge write iload and the latched tag into the latched index, set valid, and return to IDLE.
REQ-021 In FETCH with iwait=1, the block SHALL hold state, the latched address and iREN.
REQ-022 The miss latency SHALL be 1 detect cycle + FETCH cycles (the last one having iwait=0) + 1 IDLE hit cycle; a zero-wait miss therefore yields ihit in the 3rd cycle.
REQ-023 Once in FETCH, the block SHALL complete the fill even if imemREN drops or imemaddr changes.
REQ-024 A fill into a valid frame with a different tag SHALL replace the tag and data.
REQ-025 inval=1 in IDLE SHALL clear all valid bits on that edge and SHALL NOT start a fetch.
REQ-026 inval=1 during any FETCH cycle SHALL clear all valid bits and mark the pending fill as discarded; the transfer SHALL still finish on iwait=0 with the frame left invalid, and the state SHALL return to IDLE.
REQ-027 The block SHALL have only one outstanding memory request at a time.

Reset
REQ-028 nRST=1 SHALL, on the edge, clear all valid bits, set state=IDLE and clear the latched address and the discard flag; in the following cycle ihit=0, imemload=0, iREN=0 and iaddr=0.
REQ-029 Reset asserted mid-FETCH SHALL abandon the fill with no frame written, and iREN SHALL be 0 in the next cycle.
REQ-030 Reset SHALL take priority over inval and over a fill completion on the same edge.

Verification
REQ-031 Cold read: reset, then imemREN=1 with imemaddr=0x00000040, and the memory controller returning iload=0xDEADBEEF after 2 iwait=1 cycles -> iREN=1 with iaddr=0x40 for 3 cycles, then ihit=1 with imemload=0xDEADBEEF; a repeat read hits in 1 cycle with iREN=0.
REQ-032 Conflict: fill 0x40 (index 0) and then read 0x80 (SETS=16, same index, new tag) -> miss and fill; re-reading 0x40 misses again.
REQ-033 Invalidate: fill 0x40 and 0x44, then pulse inval=1 for 1 cycle -> ihit=0 during the pulse; the next reads of 0x40 and 0x44 both miss.
REQ-034 inval during FETCH: miss on 0x48, pulse inval while iwait=1 -> fill completes, state returns to IDLE, and re-reading 0x48 misses.
REQ-035 Reset mid-FETCH: miss on 0x4C, assert nRST=1 while iwait=1 -> next cycle iREN=0; after release, reading 0x4C misses.
REQ-036 Byte offset: fill 0x40, then read 0x43 -> ihit=1 with the same data and iaddr never 0x43.
